// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, special encodings and operand unpacking
// for the floating-point datapath blocks.
package fp32_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MAN_W   = FRAC_W + 1;
    localparam int BIAS    = 127;
    localparam int LATENCY = 3;

    localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
    localparam logic [31:0] FP32_POS_INF = 32'h7F800000;
    localparam logic [31:0] FP32_NEG_INF = 32'hFF800000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
    } fp_fields_t;

    // Denormals collapse to signed zero; normals get the hidden 1 restored.
    function automatic fp_fields_t fp_unpack(input logic [31:0] x);
        fp_fields_t f;
        f.sign    = x[31];
        f.exp     = x[30:23];
        f.is_zero = (x[30:23] == '0);
        f.is_inf  = (&x[30:23]) && (x[22:0] == '0);
        f.is_nan  = (&x[30:23]) && (x[22:0] != '0);
        f.man     = f.is_zero ? '0 : {1'b1, x[22:0]};
        return f;
    endfunction

endpackage

// File: rtl/fp_adder_block_lzc28.sv
// 28-bit leading-zero counter; an all-zero input reports 28.
module lzc28 (
    input  logic [27:0] x,
    output logic [4:0]  count
);

    // Scanning upward lets the highest set bit overwrite lower ones.
    always_comb begin
        count = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (x[i]) count = 5'(27 - i);
        end
    end

endmodule

// File: rtl/fp_adder_block.sv
// Three-stage binary32 adder: unpack/compare, align/add, normalize/round/pack.
// in_valid is a plain qualifier with no ready: every edge samples A/B and out_valid echoes in_valid 3 edges later.
module fp_adder_block
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] R,
    output logic        out_valid
);

    localparam logic signed [9:0] E_MAX = 10'(2 * BIAS + 1);

    // ---------------- stage 1: unpack / compare ----------------
    fp_fields_t fa, fb;
    logic [30:0] mag_a, mag_b;
    logic        a_big;
    logic        c1_spec;
    logic [31:0] c1_spec_val;

    logic             s1_sign, s1_sub, s1_spec;
    logic [EXP_W-1:0] s1_exp, s1_d;
    logic [MAN_W-1:0] s1_big_man, s1_sml_man;
    logic [31:0]      s1_spec_val;

    always_comb begin
        fa    = fp_unpack(A);
        fb    = fp_unpack(B);
        mag_a = fa.is_zero ? '0 : A[30:0];
        mag_b = fb.is_zero ? '0 : B[30:0];
        a_big = (mag_a >= mag_b);
    end

    // Specials and zero operands bypass the arithmetic path entirely.
    always_comb begin
        c1_spec     = 1'b1;
        c1_spec_val = '0;
        if (fa.is_nan || fb.is_nan || (fa.is_inf && fb.is_inf && (fa.sign != fb.sign)))
            c1_spec_val = FP32_QNAN;
        else if (fa.is_inf)
            c1_spec_val = A;
        else if (fb.is_inf)
            c1_spec_val = B;
        else if (fa.is_zero && fb.is_zero)
            c1_spec_val = {fa.sign & fb.sign, 31'b0};
        else if (fa.is_zero)
            c1_spec_val = B;
        else if (fb.is_zero)
            c1_spec_val = A;
        else
            c1_spec = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sign     <= 1'b0;
            s1_sub      <= 1'b0;
            s1_spec     <= 1'b0;
            s1_exp      <= '0;
            s1_d        <= '0;
            s1_big_man  <= '0;
            s1_sml_man  <= '0;
            s1_spec_val <= '0;
        end else begin
            s1_sign     <= a_big ? fa.sign : fb.sign;
            s1_sub      <= fa.sign ^ fb.sign;
            s1_spec     <= c1_spec;
            s1_exp      <= a_big ? fa.exp : fb.exp;
            s1_d        <= a_big ? (fa.exp - fb.exp) : (fb.exp - fa.exp);
            s1_big_man  <= a_big ? fa.man : fb.man;
            s1_sml_man  <= a_big ? fb.man : fa.man;
            s1_spec_val <= c1_spec_val;
        end
    end

    // ---------------- stage 2: align / add ----------------
    logic [53:0] wide;
    logic [26:0] al;
    logic [27:0] c2_sum;

    always_comb begin
        wide   = {s1_sml_man, 3'b000, 27'b0} >> s1_d;
        al     = (s1_d >= 8'd27) ? 27'd1 : {wide[53:28], wide[27] | (|wide[26:0])};
        c2_sum = s1_sub ? ({1'b0, s1_big_man, 3'b000} - {1'b0, al})
                        : ({1'b0, s1_big_man, 3'b000} + {1'b0, al});
    end

    logic             s2_sign, s2_spec;
    logic [EXP_W-1:0] s2_exp;
    logic [27:0]      s2_sum;
    logic [31:0]      s2_spec_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_sign     <= 1'b0;
            s2_spec     <= 1'b0;
            s2_exp      <= '0;
            s2_sum      <= '0;
            s2_spec_val <= '0;
        end else begin
            s2_sign     <= s1_sign;
            s2_spec     <= s1_spec;
            s2_exp      <= s1_exp;
            s2_sum      <= c2_sum;
            s2_spec_val <= s1_spec_val;
        end
    end

    // ---------------- stage 3: normalize / round / pack ----------------
    logic [4:0]         lz;
    logic [26:0]        n;
    logic signed [9:0]  e_norm, e_r;
    logic               up;
    logic [24:0]        m25;
    logic [FRAC_W-1:0]  frac;
    logic [31:0]        c3_res;

    lzc28 u_lzc (
        .x     (s2_sum),
        .count (lz)
    );

    always_comb begin
        if (s2_sum[27]) begin
            n      = {s2_sum[27:2], s2_sum[1] | s2_sum[0]};
            e_norm = $signed({2'b00, s2_exp}) + 10'sd1;
        end else begin
            n      = s2_sum[26:0] << (lz - 5'd1);
            e_norm = $signed({2'b00, s2_exp}) - $signed({5'b00000, lz - 5'd1});
        end
        // n = {1.frac[22:0], guard, round, sticky}
        up  = n[2] & (n[1] | n[0] | n[3]);
        m25 = {1'b0, n[26:3]} + {24'b0, up};
        if (m25[24]) begin
            e_r  = e_norm + 10'sd1;
            frac = m25[23:1];
        end else begin
            e_r  = e_norm;
            frac = m25[22:0];
        end
        if (s2_spec)
            c3_res = s2_spec_val;
        else if (s2_sum == '0)
            c3_res = '0;
        else if (e_r >= E_MAX)
            c3_res = s2_sign ? FP32_NEG_INF : FP32_POS_INF;
        else if (e_r <= 10'sd0)
            c3_res = {s2_sign, 31'b0};
        else
            c3_res = {s2_sign, e_r[7:0], frac};
    end

    logic [LATENCY-1:0] v_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            R      <= '0;
            v_pipe <= '0;
        end else begin
            R      <= c3_res;
            v_pipe <= {v_pipe[LATENCY-2:0], in_valid};
        end
    end

    assign out_valid = v_pipe[LATENCY-1];

endmodule

// File: tb/tb_fp_adder_block.sv
// Bench for fp_adder_block: directed vector table, reset sequences and
// randomized operands checked against an exact-arithmetic reference model.
module tb_fp_adder_block;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] A, B, R;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q[$];
    string       tag_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[22];

    fp_adder_block dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .R         (R),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Exact sum of two binary32 values, rounded once to nearest-even.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic   sa, sb, za, zb, nan_a, nan_b, inf_a, inf_b, sr;
        int     ea, eb, emin, p, sh, e;
        longint va, vb, sum, mag, q, rem, half;
        sa = a[31]; sb = b[31];
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        za = (ea == 0); zb = (eb == 0);
        nan_a = (ea == 255) && (a[22:0] != 0);
        nan_b = (eb == 255) && (b[22:0] != 0);
        inf_a = (ea == 255) && (a[22:0] == 0);
        inf_b = (eb == 255) && (b[22:0] == 0);
        if (nan_a || nan_b) return 32'h7FC00000;
        if (inf_a && inf_b) return (sa == sb) ? a : 32'h7FC00000;
        if (inf_a) return a;
        if (inf_b) return b;
        if (za && zb) return {sa & sb, 31'b0};
        if (za) return b;
        if (zb) return a;
        // Beyond 30 binades the smaller operand is under a quarter ulp.
        if (ea - eb > 30) return a;
        if (eb - ea > 30) return b;
        emin = (ea < eb) ? ea : eb;
        va = (longint'(a[22:0]) + (longint'(1) << 23)) << (ea - emin);
        vb = (longint'(b[22:0]) + (longint'(1) << 23)) << (eb - emin);
        if (sa) va = -va;
        if (sb) vb = -vb;
        sum = va + vb;
        if (sum == 0) return 32'h00000000;
        sr  = (sum < 0);
        mag = sr ? -sum : sum;
        p = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) p = i;
        if (p > 23) begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q  = q >> 1;
                sh = sh + 1;
            end
        end else begin
            sh = p - 23;
            q  = mag << (23 - p);
        end
        e = emin + sh;
        if (e >= 255) return sr ? 32'hFF800000 : 32'h7F800000;
        if (e <= 0) return {sr, 31'b0};
        return {sr, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp(input int ebase);
        int          k, e;
        logic [31:0] f;
        k = $urandom_range(0, 31);
        f = $urandom;
        if (k == 0) begin
            e = 0;
            if ($urandom_range(0, 1) == 0) f = 0;
        end else if (k == 1) begin
            e = 255;
            if ($urandom_range(0, 1) == 0) f = 0;
        end else if (k == 2) begin
            e = $urandom_range(1, 254);
        end else begin
            e = ebase + $urandom_range(0, 60) - 30;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
        end
        return {f[31], e[7:0], f[22:0]};
    endfunction

    task automatic check_out();
        logic [32:0] e;
        string       t;
        if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            total++;
            if (out_valid !== e[32]) begin
                bad++;
                $display("FAIL %s out_valid got=%b exp=%b", t, out_valid, e[32]);
            end
            if (e[32]) begin
                total++;
                if (R !== e[31:0]) begin
                    bad++;
                    $display("FAIL %s R got=%h exp=%h (A/B earlier)", t, R, e[31:0]);
                end
            end
        end
    endtask

    // One clock of stimulus; the result is checked three negedges later.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input string name);
        @(negedge clk);
        check_out();
        in_valid = v;
        A        = a;
        B        = b;
        exp_q.push_back({v, v ? r : 32'h0});
        tag_q.push_back(name);
    endtask

    task automatic check_idle_regs(input string name);
        total++;
        if (R !== 32'h0) begin
            bad++;
            $display("FAIL %s R got=%h exp=00000000", name, R);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s out_valid got=%b exp=0", name, out_valid);
        end
    endtask

    task automatic release_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        tag_q.delete();
        repeat (3) begin
            exp_q.push_back(33'h0);
            tag_q.push_back("post_reset_idle");
        end
    endtask

    initial begin
        logic [31:0] a, b;
        int          eb;

        vecs[0]  = '{32'h30000100, 32'h100007D0, 32'h30000100};
        vecs[1]  = '{32'hB0000100, 32'h100007D0, 32'hB0000100};
        vecs[2]  = '{32'h30000100, 32'h900007D0, 32'h30000100};
        vecs[3]  = '{32'hB0000100, 32'h900007D0, 32'hB0000100};
        vecs[4]  = '{32'h3F800000, 32'h3F800000, 32'h40000000};
        vecs[5]  = '{32'h3FC00000, 32'h40200000, 32'h40800000};
        vecs[6]  = '{32'h40400000, 32'hBF800000, 32'h40000000};
        vecs[7]  = '{32'h3F800000, 32'hBF800000, 32'h00000000};
        vecs[8]  = '{32'h80000000, 32'h80000000, 32'h80000000};
        vecs[9]  = '{32'h4B000000, 32'h3F000000, 32'h4B000000};
        vecs[10] = '{32'h4B000001, 32'h3F000000, 32'h4B000002};
        vecs[11] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
        vecs[12] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000};
        vecs[13] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000};
        vecs[14] = '{32'hBF800000, 32'h3F800000, 32'h00000000};
        vecs[15] = '{32'h00000000, 32'h80000000, 32'h00000000};
        vecs[16] = '{32'h00400000, 32'h3F800000, 32'h3F800000};
        vecs[17] = '{32'h7F800000, 32'h3F800000, 32'h7F800000};
        vecs[18] = '{32'hFF800000, 32'hFF800000, 32'hFF800000};
        vecs[19] = '{32'h3F800000, 32'hC0000000, 32'hBF800000};
        vecs[20] = '{32'h00800001, 32'h80800000, 32'h00000000};
        vecs[21] = '{32'h80400000, 32'h80000000, 32'h80000000};

        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        repeat (2) @(negedge clk);
        #1;
        check_idle_regs("reset_state");
        release_reset();

        // Table applied back-to-back: one operation per clock, in order.
        for (int i = 0; i < 22; i++)
            step(1'b1, vecs[i].a, vecs[i].b, vecs[i].r, $sformatf("vec%0d", i));

        // Mid-stream reset: in-flight results must vanish without a clock edge.
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h3F800000 + i, 32'h40000000, ref_add(32'h3F800000 + i, 32'h40000000),
                 $sformatf("pre_rst%0d", i));
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_idle_regs("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check_idle_regs("rst_held");
        release_reset();

        for (int i = 0; i < 8; i++) begin
            a = rand_fp($urandom_range(1, 254));
            b = rand_fp(int'(a[30:23]));
            step(1'b1, a, b, ref_add(a, b), $sformatf("b2b%0d", i));
        end

        for (int i = 0; i < 600; i++) begin
            eb = $urandom_range(1, 254);
            a  = rand_fp(eb);
            b  = rand_fp(eb);
            if ($urandom_range(0, 15) == 0) b = a ^ 32'h80000000;
            step($urandom_range(0, 3) != 0, a, b, ref_add(a, b), $sformatf("rnd%0d", i));
        end

        repeat (4) step(1'b0, 32'h0, 32'h0, 32'h0, "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_adder_block.md
Name: fp_adder_block

Overview:
- Pipelined IEEE-754 single-precision floating-point adder: R = A + B.
- Arithmetic core of the 8-point 2D-DCT datapath, used for butterfly sums and differences. A subtraction is performed by the caller flipping bit 31 of B.
- Fixed 3-cycle latency. Accepts one operation per clock.

Parameters:
- LATENCY, 3, pipeline depth in clocks from input sample to R/out_valid. Fixed; it is documented here but not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  A/B valid this cycle.
- A  input  32  operand A, IEEE-754 binary32 (sign 31, exponent 30:23, fraction 22:0).
- B  input  32  operand B, same format.
- R  output  32  sum, binary32, registered.
- out_valid  output  1  R holds the result of the in_valid sample from 3 cycles earlier.

Behaviour:
- Reset: while rst=1, all pipeline registers, R and out_valid are forced to 0 asynchronously. An operation in flight when reset asserts is discarded. Normal operation resumes on the first rising clk after rst deasserts.
- Pipeline: A/B are sampled on every clk edge. The result appears on R exactly 3 edges later, with out_valid = in_valid delayed by 3. No stall and no backpressure.
- R is computed on every cycle. It is meaningful only when out_valid=1.
- Stage 1 (unpack/compare):
  - Unpack fields and restore the hidden 1.
  - Swap operands so the larger magnitude is the "big" operand.
  - Compute the exponent difference d.
  - Classify each operand as zero, inf, NaN or normal.
- Stage 2 (align/add):
  - Shift the small mantissa right by d, keeping guard, round and sticky bits. If d ≥ 27, the small mantissa becomes sticky only.
  - Add when signs match, otherwise subtract (big minus small).
- Stage 3 (normalize/round/pack):
  - Normalize using a leading-zero count; a carry-out produces a right shift by 1.
  - Round to nearest, ties to even. Renormalize if rounding overflows the mantissa.
- Sign: the result takes the sign of the larger-magnitude operand.
- Exact cancellation (x + (−x)) gives +0.
- Zeros: (−0)+(−0) = −0. Any other combination of zeros gives +0.
- Denormal inputs are flushed to zero (treated as signed zero).
- Denormal results are flushed to signed zero.
- Overflow (exponent ≥ 255 after rounding) gives ±inf, 0x7F800000 or 0xFF800000.
- NaN input, or inf + (−inf), gives canonical qNaN 0x7FC00000.
- inf + finite gives that inf. inf + same-sign inf gives inf.
- No exception flags are produced.

Decomposition:
- Shared package fp32_pkg:
  - Field widths: EXP_W=8, FRAC_W=23, BIAS=127.
  - Constants: FP32_QNAN=32'h7FC00000, FP32_POS_INF=32'h7F800000, FP32_NEG_INF=32'hFF800000.
  - A struct typedef for unpacked operand fields.
- One sub-module: lzc28, a 28-bit leading-zero counter used in stage 3.
- The alignment shifter stays inline.

Test Plan:
- Widely separated exponents (d=64):
  - A=0x30000100, B=0x100007D0 -> R=0x30000100.
  - A=0xB0000100, B=0x100007D0 -> R=0xB0000100.
  - A=0x30000100, B=0x900007D0 -> R=0x30000100.
  - A=0xB0000100, B=0x900007D0 -> R=0xB0000100.
  - Each result is checked exactly 3 cycles after its input.
- Normal adds:
  - 0x3F800000+0x3F800000 -> 0x40000000.
  - 0x3FC00000+0x40200000 -> 0x40800000.
  - 0x40400000+0xBF800000 -> 0x40000000.
- Cancellation and zeros:
  - 0x3F800000+0xBF800000 -> 0x00000000.
  - 0x80000000+0x80000000 -> 0x80000000.
- Rounding tie-to-even:
  - 0x4B000000+0x3F000000 -> 0x4B000000.
  - 0x4B000001+0x3F000000 -> 0x4B000002.
- Specials:
  - 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000.
  - 0x7F800000+0xFF800000 -> 0x7FC00000.
  - 0x7FC00001+0x3F800000 -> 0x7FC00000.
- Pipeline and reset:
  - Back-to-back in_valid for 8 cycles -> 8 consecutive out_valid results in order.
  - Assert rst mid-stream -> R=0 and out_valid=0 immediately, without waiting for a clock edge; no stale results after release.
